// File: rtl/multicycle_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_seq_ctrl_if
// Memory handshake bundle between the sequencing controller and the
// instruction / data memories.
//   imem_req  controller -> imem   instruction fetch request
//   imem_ack  imem -> controller   instruction word valid
//   dmem_req  controller -> dmem   data access request
//   dmem_we   controller -> dmem   data access is a store
//   dmem_ack  dmem -> controller   data access complete
// master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_seq_ctrl_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_seq_ctrl
// Multi-cycle sequencer for the RV32I subset datapath. Walks the shared
// datapath through FETCH / DECODE / EXEC / MEM / WB, handshakes with the
// instruction and data memories, picks the next-PC source, handles ecall
// halt / display and keeps cycle and retired-instruction counters.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   i_start            start from IDLE or resume from HALT
//   i_mem_to_reg .. i_jalr  decoded control bits (stable DECODE..WB)
//   i_alu_zero         rs1 == rs2, valid in EXEC
//   i_a7_val           register a7, valid in EXEC
//   mem_if             imem/dmem handshake (master side)
//   o_ir_we            latch instruction register
//   o_rf_we            register file write
//   o_pc_we            PC update
//   o_pc_sel           0 = pc+4, 1 = branch/jal target, 2 = jalr target
//   o_ecall_show       one-cycle display pulse for a non-halt ecall
//   o_halted           machine sits in HALT
//   o_state            current state encoding
//   o_cycle_cnt        active (non IDLE/HALT) cycles, wraps
//   o_instr_cnt        retired instructions, wraps
// -----------------------------------------------------------------------------
module multicycle_seq_ctrl #(
   parameter int          CNT_W     = 32,
   parameter logic [31:0] HALT_CODE = 32'd10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_mem_to_reg,
   input  logic                  i_mem_write,
   input  logic                  i_reg_write,
   input  logic                  i_ecall,
   input  logic                  i_beq,
   input  logic                  i_bne,
   input  logic                  i_jal,
   input  logic                  i_jalr,
   input  logic                  i_alu_zero,
   input  logic [31:0]           i_a7_val,
   multicycle_seq_ctrl_if.master mem_if,
   output logic                  o_ir_we,
   output logic                  o_rf_we,
   output logic                  o_pc_we,
   output logic [1:0]            o_pc_sel,
   output logic                  o_ecall_show,
   output logic                  o_halted,
   output logic [2:0]            o_state,
   output logic [CNT_W-1:0]      o_cycle_cnt,
   output logic [CNT_W-1:0]      o_instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic [1:0]       r_pc_sel_q;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;

   logic             w_halt_ecall;
   logic [1:0]       w_pc_sel_d;
   logic             w_active;

   // Halting ecall is the only EXEC case that retires without a WB cycle.
   assign w_halt_ecall = (r_state == S_EXEC) && i_ecall && (i_a7_val == HALT_CODE);

   // Next-PC source, resolved in EXEC and held in r_pc_sel_q until WB.
   always_comb begin
      w_pc_sel_d = 2'd0;
      if (i_jalr)
         w_pc_sel_d = 2'd2;
      else if (i_jal || (i_beq && i_alu_zero) || (i_bne && !i_alu_zero))
         w_pc_sel_d = 2'd1;
   end

   // State code 7 is not counted; it only lasts one edge before recovery.
   assign w_active = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                     (r_state == S_EXEC)  || (r_state == S_MEM)    ||
                     (r_state == S_WB);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc_sel_q  <= 2'd0;
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if (w_active)
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         case (r_state)
            S_IDLE:   if (i_start) r_state <= S_FETCH;
            S_FETCH:  if (mem_if.imem_ack) r_state <= S_DECODE;
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               r_pc_sel_q <= w_pc_sel_d;
               if (w_halt_ecall) begin
                  r_instr_cnt <= r_instr_cnt + CNT_ONE;
                  r_state     <= S_HALT;
               end else if (i_ecall)
                  r_state <= S_WB;
               else if (i_mem_to_reg || i_mem_write)
                  r_state <= S_MEM;
               else
                  r_state <= S_WB;
            end
            S_MEM:    if (mem_if.dmem_ack) r_state <= S_WB;
            S_WB: begin
               r_instr_cnt <= r_instr_cnt + CNT_ONE;
               r_state     <= S_FETCH;
            end
            S_HALT:   if (i_start) r_state <= S_FETCH;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from the state register so that reset clears
   // every request on the same edge; ir_we and the halt-cycle pc_we also
   // follow same-cycle inputs.
   always_comb begin
      mem_if.imem_req = 1'b0;
      mem_if.dmem_req = 1'b0;
      mem_if.dmem_we  = 1'b0;
      o_ir_we         = 1'b0;
      o_rf_we         = 1'b0;
      o_pc_we         = 1'b0;
      o_pc_sel        = 2'd0;
      o_ecall_show    = 1'b0;
      o_halted        = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_if.imem_req = 1'b1;
            o_ir_we         = mem_if.imem_ack;
         end
         S_EXEC: begin
            if (w_halt_ecall)
               o_pc_we = 1'b1;
            else if (i_ecall)
               o_ecall_show = 1'b1;
         end
         S_MEM: begin
            mem_if.dmem_req = 1'b1;
            mem_if.dmem_we  = i_mem_write;
         end
         S_WB: begin
            o_rf_we  = i_reg_write;
            o_pc_we  = 1'b1;
            o_pc_sel = r_pc_sel_q;
         end
         S_HALT:  o_halted = 1'b1;
         default: ;
      endcase
   end

   assign o_state     = r_state;
   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_seq_ctrl
// Scoreboard bench: each scenario pushes per-cycle stimulus plus the
// expected controller outputs for that cycle, then drains the queue one
// clock at a time, comparing the DUT outputs against the popped entry.
// -----------------------------------------------------------------------------
module tb_multicycle_seq_ctrl;

   localparam logic O = 1'b0;
   localparam logic I = 1'b1;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mem_to_reg, mem_write, reg_write, ecall, beq, bne, jal, jalr;
   logic        alu_zero;
   logic [31:0] a7_val;
   logic        ir_we, rf_we, pc_we, ecall_show, halted;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, instr_cnt;

   multicycle_seq_ctrl_if bus ();

   multicycle_seq_ctrl #(
      .CNT_W     (32),
      .HALT_CODE (32'd10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (start),
      .i_mem_to_reg (mem_to_reg),
      .i_mem_write  (mem_write),
      .i_reg_write  (reg_write),
      .i_ecall      (ecall),
      .i_beq        (beq),
      .i_bne        (bne),
      .i_jal        (jal),
      .i_jalr       (jalr),
      .i_alu_zero   (alu_zero),
      .i_a7_val     (a7_val),
      .mem_if       (bus),
      .o_ir_we      (ir_we),
      .o_rf_we      (rf_we),
      .o_pc_we      (pc_we),
      .o_pc_sel     (pc_sel),
      .o_ecall_show (ecall_show),
      .o_halted     (halted),
      .o_state      (state),
      .o_cycle_cnt  (cycle_cnt),
      .o_instr_cnt  (instr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       start;
      logic       iack;
      logic       dack;
      logic [2:0] st;
      logic       ireq;
      logic       irwe;
      logic       dreq;
      logic       dwe;
      logic       rfwe;
      logic       pcwe;
      logic [1:0] psel;
      logic       show;
      logic       hlt;
   } ent_t;

   ent_t  sb[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc   = 0;
   string tag   = "";

   task automatic push(input logic s, input logic ia, input logic da, input logic [2:0] st,
                       input logic ireq, input logic irwe, input logic dreq, input logic dwe,
                       input logic rfwe, input logic pcwe, input logic [1:0] psel,
                       input logic show, input logic hlt);
      ent_t e;
      e.start = s;    e.iack = ia;    e.dack = da;   e.st   = st;
      e.ireq  = ireq; e.irwe = irwe;  e.dreq = dreq; e.dwe  = dwe;
      e.rfwe  = rfwe; e.pcwe = pcwe;  e.psel = psel; e.show = show;
      e.hlt   = hlt;
      sb.push_back(e);
   endtask

   task automatic p_idle(input logic s);
      push(s, O, O, 3'd0, O, O, O, O, O, O, 2'd0, O, O);
   endtask
   task automatic p_fetch(input logic ack, input logic s);
      push(s, ack, O, 3'd1, I, ack, O, O, O, O, 2'd0, O, O);
   endtask
   // Both acks driven high while no request is up: must be ignored.
   task automatic p_dec();
      push(O, I, I, 3'd2, O, O, O, O, O, O, 2'd0, O, O);
   endtask
   task automatic p_exec(input logic pcwe, input logic show);
      push(O, O, O, 3'd3, O, O, O, O, O, pcwe, 2'd0, show, O);
   endtask
   task automatic p_mem(input logic ack, input logic we);
      push(O, O, ack, 3'd4, O, O, I, we, O, O, 2'd0, O, O);
   endtask
   task automatic p_wb(input logic rfwe, input logic [1:0] psel);
      push(O, O, O, 3'd5, O, O, O, O, rfwe, I, psel, O, O);
   endtask
   task automatic p_halt(input logic s);
      push(s, O, O, 3'd6, O, O, O, O, O, O, 2'd0, O, I);
   endtask

   // Invariant between tasks: time is 1 unit after a rising edge.
   task automatic step();
      ent_t       e;
      logic [12:0] got, want;
      e            = sb.pop_front();
      start        = e.start;
      bus.imem_ack = e.iack;
      bus.dmem_ack = e.dack;
      #2;
      got  = {state, bus.imem_req, ir_we, bus.dmem_req, bus.dmem_we, rf_we, pc_we,
              pc_sel, ecall_show, halted};
      want = {e.st, e.ireq, e.irwe, e.dreq, e.dwe, e.rfwe, e.pcwe, e.psel, e.show, e.hlt};
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cycle %0d outputs(st,ireq,irwe,dreq,dwe,rfwe,pcwe,psel,show,hlt): got %b want %b",
                  tag, cyc, got, want);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      while (sb.size() > 0) step();
   endtask

   task automatic set_ctl(input logic m2r, input logic mw, input logic rw, input logic ec,
                          input logic bq, input logic bn, input logic j, input logic jr,
                          input logic z, input logic [31:0] a7);
      mem_to_reg = m2r; mem_write = mw; reg_write = rw; ecall = ec;
      beq = bq; bne = bn; jal = j; jalr = jr; alu_zero = z; a7_val = a7;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      tag   = "reset";
      rst_n = 1'b0;
      start = 1'b1;   // reset must win over start
      set_ctl(O, O, O, O, O, O, O, O, O, 32'd0);
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
      n_vec++;
      if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); end
      n_vec++;
      if (instr_cnt !== 32'd0) begin n_err++; $display("FAIL reset_instr_cnt got %0d want 0", instr_cnt); end
      rst_n = 1'b1;
      start = 1'b0;
      p_idle(O); p_idle(O); p_idle(O);
      drain();
   endtask

   task automatic test_add();
      do_reset();
      tag = "add";
      set_ctl(O, O, I, O, O, O, O, O, O, 32'd0);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(I, 2'd0);
      drain();
      n_vec++;
      if (cycle_cnt !== 32'd4) begin n_err++; $display("FAIL add_cycle_cnt got %0d want 4", cycle_cnt); end
      n_vec++;
      if (instr_cnt !== 32'd1) begin n_err++; $display("FAIL add_instr_cnt got %0d want 1", instr_cnt); end
      p_fetch(O, O);
      drain();
   endtask

   task automatic test_load_wait();
      do_reset();
      tag = "lw_wait";
      set_ctl(I, O, I, O, O, O, O, O, O, 32'd0);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, O);
      p_mem(O, O); p_mem(O, O); p_mem(O, O); p_mem(I, O);
      p_wb(I, 2'd0);
      drain();
      n_vec++;
      if (cycle_cnt !== 32'd8) begin n_err++; $display("FAIL lw_cycle_cnt got %0d want 8", cycle_cnt); end
      n_vec++;
      if (instr_cnt !== 32'd1) begin n_err++; $display("FAIL lw_instr_cnt got %0d want 1", instr_cnt); end
   endtask

   task automatic test_store_fetch_wait();
      do_reset();
      tag = "sw_fetch_wait";
      set_ctl(O, I, O, O, O, O, O, O, O, 32'd0);
      // start pulses inside FETCH must be ignored
      p_idle(I); p_fetch(O, I); p_fetch(O, I); p_fetch(I, O); p_dec(); p_exec(O, O);
      p_mem(I, I); p_wb(O, 2'd0);
      drain();
      n_vec++;
      if (cycle_cnt !== 32'd7) begin n_err++; $display("FAIL sw_cycle_cnt got %0d want 7", cycle_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      tag = "beq_taken";
      set_ctl(O, O, O, O, I, O, O, O, I, 32'd0);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(O, 2'd1);
      drain();
      tag = "beq_not_taken";
      set_ctl(O, O, O, O, I, O, O, O, O, 32'd0);
      p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(O, 2'd0);
      drain();
      tag = "bne_taken";
      set_ctl(O, O, O, O, O, I, O, O, O, 32'd0);
      p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(O, 2'd1);
      drain();
      tag = "bne_not_taken";
      set_ctl(O, O, O, O, O, I, O, O, I, 32'd0);
      p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(O, 2'd0);
      drain();
      tag = "jal";
      set_ctl(O, O, I, O, O, O, I, O, O, 32'd0);
      p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(I, 2'd1);
      drain();
      tag = "jalr";
      set_ctl(O, O, I, O, O, O, O, I, I, 32'd0);
      p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(I, 2'd2);
      drain();
      n_vec++;
      if (instr_cnt !== 32'd6) begin n_err++; $display("FAIL b2b_instr_cnt got %0d want 6", instr_cnt); end
      n_vec++;
      if (cycle_cnt !== 32'd24) begin n_err++; $display("FAIL b2b_cycle_cnt got %0d want 24", cycle_cnt); end
   endtask

   task automatic test_ecall_halt();
      do_reset();
      tag = "ecall_halt";
      set_ctl(O, O, O, I, O, O, O, O, O, 32'd10);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(I, O);
      p_halt(O); p_halt(O); p_halt(O); p_halt(O); p_halt(O);
      drain();
      n_vec++;
      if (cycle_cnt !== 32'd3) begin n_err++; $display("FAIL halt_cycle_cnt got %0d want 3", cycle_cnt); end
      n_vec++;
      if (instr_cnt !== 32'd1) begin n_err++; $display("FAIL halt_instr_cnt got %0d want 1", instr_cnt); end
      tag = "halt_resume";
      p_halt(I); p_fetch(O, O);
      drain();
      n_vec++;
      if (cycle_cnt !== 32'd4) begin n_err++; $display("FAIL resume_cycle_cnt got %0d want 4", cycle_cnt); end
   endtask

   task automatic test_ecall_show();
      do_reset();
      tag = "ecall_show";
      set_ctl(O, O, O, I, O, O, O, O, O, 32'd1);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, I); p_wb(O, 2'd0); p_fetch(O, O);
      drain();
      n_vec++;
      if (instr_cnt !== 32'd1) begin n_err++; $display("FAIL show_instr_cnt got %0d want 1", instr_cnt); end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      tag = "reset_mid_mem";
      set_ctl(O, I, O, O, O, O, O, O, O, 32'd0);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, O); p_mem(O, I); p_mem(O, I);
      drain();
      rst_n = 1'b0; start = 1'b1; bus.dmem_ack = 1'b0; bus.imem_ack = 1'b0;
      #2;
      n_vec++;
      if (bus.dmem_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_dmem_req got %b want 1", bus.dmem_req); end
      @(posedge clk);
      #1;
      n_vec++;
      if (state !== 3'd0) begin n_err++; $display("FAIL mid_reset_state got %0d want 0", state); end
      n_vec++;
      if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL mid_reset_dmem_req got %b want 0", bus.dmem_req); end
      n_vec++;
      if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL mid_reset_counters got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
      end
      rst_n = 1'b1;
      start = 1'b0;
      // undefined instruction: all-zero control bits behave as a NOP
      tag = "nop";
      set_ctl(O, O, O, O, O, O, O, O, O, 32'd0);
      p_idle(I); p_fetch(I, O); p_dec(); p_exec(O, O); p_wb(O, 2'd0); p_fetch(O, O);
      drain();
      n_vec++;
      if (instr_cnt !== 32'd1) begin n_err++; $display("FAIL nop_instr_cnt got %0d want 1", instr_cnt); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_store_fetch_wait();
      test_back_to_back();
      test_ecall_halt();
      test_ecall_show();
      test_reset_mid_mem();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
